mac_psum_quantizer: RTL

Downstream of the 4-bit MAC stage: collects the MAC's 10-bit results one `in_valid` pulse at a time and sums `ACC_LEN` of them into one output-pixel partial sum (default 3x3 kernel). Each completed sum is processed as follows:
- add a signed bias;
- apply ReLU;
- right-shift and saturate to a 4-bit activation;
- buffer it in a small FIFO.

The FIFO drains over a valid/ready handshake, producing activations in the same 4-bit format the MAC consumes as IFM, so the next layer can reuse it directly.

---
 rtl/mac_psum_quantizer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mac_psum_quantizer.sv
// Sums ACC_LEN MAC results into one pixel partial sum, applies bias, ReLU and a
// shift with 4-bit saturation, and queues the activations in a small FIFO.
module mac_psum_quantizer #(
    parameter int ACC_LEN = 9,
    parameter int ACC_W   = 14,
    parameter int SHIFT   = 2,
    parameter int DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             in_valid,
    input  logic [9:0]                       in_data,
    input  logic [7:0]                       bias,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [3:0]                       out,
    output logic                             ovf,
    output logic [$clog2(ACC_LEN+1)-1:0]     win_cnt
);
    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

    typedef enum logic {ACC_IDLE = 1'b0, ACC_RUN = 1'b1} acc_state_t;

    acc_state_t         state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   win_cnt_q;
    logic [ACC_W-1:0]   fin_sum_q;
    logic [7:0]         fin_bias_q;
    logic               fin_pend_q;
    logic [3:0]         mem_q [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   acc_base_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic [3:0]         fin_q_s;
    logic               empty_s, full_s, pop_s, wr_en_s;

    // Bias add at ACC_W+1 bits (MSB is the sign), then ReLU, shift and clamp to 4 bits.
    function automatic logic [3:0] quantize(input logic [ACC_W-1:0] sum, input logic [7:0] b);
        logic [ACC_W:0] s;
        logic [ACC_W:0] r;
        s = {1'b0, sum} + {{(ACC_W-7){b[7]}}, b};
        r = s >> SHIFT;
        if (s[ACC_W]) begin
            quantize = 4'd0;
        end else if (r > {{(ACC_W-3){1'b0}}, 4'd15}) begin
            quantize = 4'd15;
        end else begin
            quantize = r[3:0];
        end
    endfunction

    // Accumulator operand: a fresh window always starts from zero.
    always_comb begin
        acc_base_s = '0;
        case (state_q)
            ACC_RUN:  acc_base_s = acc_q;
            default:  acc_base_s = '0;
        endcase
        acc_sum_s = acc_base_s + {{(ACC_W-10){1'b0}}, in_data};
    end

    // Accumulate FSM and the one-deep fin stage feeding the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC_IDLE;
            acc_q      <= '0;
            win_cnt_q  <= '0;
            fin_sum_q  <= '0;
            fin_bias_q <= 8'd0;
            fin_pend_q <= 1'b0;
        end else if (clr) begin
            state_q    <= ACC_IDLE;
            acc_q      <= '0;
            win_cnt_q  <= '0;
            fin_sum_q  <= '0;
            fin_bias_q <= 8'd0;
            fin_pend_q <= 1'b0;
        end else begin
            fin_pend_q <= 1'b0;
            if (in_valid) begin
                if (win_cnt_q == LAST_CNT) begin
                    fin_sum_q  <= acc_sum_s;
                    fin_bias_q <= bias;
                    fin_pend_q <= 1'b1;
                    acc_q      <= '0;
                    win_cnt_q  <= '0;
                    state_q    <= ACC_IDLE;
                end else begin
                    acc_q      <= acc_sum_s;
                    win_cnt_q  <= win_cnt_q + CNT_W'(1);
                    state_q    <= ACC_RUN;
                end
            end else begin
                acc_q     <= acc_q;
                win_cnt_q <= win_cnt_q;
            end
        end
    end

    assign fin_q_s = quantize(fin_sum_q, fin_bias_q);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_s   = !empty_s && out_ready;

    // FIFO next state; a push into a full FIFO only lands if a pop frees a slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        wr_en_s  = 1'b0;
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (fin_pend_q) begin
            if (!full_s || pop_s) begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // FIFO storage, pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            if (wr_en_s) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= fin_q_s;
            end
        end
    end

    assign out_valid = !empty_s;
    assign out       = empty_s ? 4'd0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign ovf       = ovf_q;
    assign win_cnt   = win_cnt_q;
endmodule
